// File: rtl/dm_cache_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dm_cache_pkg
// Brief    : Shared types, widths and address field helpers for dm_wb_cache.
// Revision : 1.0 - initial release
// ============================================================================
package dm_cache_pkg;

  localparam int OFS_W    = 4;
  localparam int WORDS    = 4;
  localparam int ADDR_MAX = 64;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    WB_REQ  = 4'd1,
    WB_WAIT = 4'd2,
    AL_REQ  = 4'd3,
    AL_WAIT = 4'd4,
    FL_SCAN = 4'd5,
    FL_REQ  = 4'd6,
    FL_WAIT = 4'd7,
    DONE    = 4'd8
  } state_e;

  function automatic int line_w(input int bit_w);
    return WORDS * bit_w;
  endfunction

  function automatic int tag_w(input int addr_w, input int idx_w);
    return addr_w - idx_w - OFS_W;
  endfunction

  // Helpers operate on a zero-extended address; callers truncate the result.
  function automatic logic [ADDR_MAX-1:0] addr_tag(input logic [ADDR_MAX-1:0] a, input int idx_w);
    return a >> (idx_w + OFS_W);
  endfunction

  function automatic logic [ADDR_MAX-1:0] addr_idx(input logic [ADDR_MAX-1:0] a, input int idx_w);
    return (a >> OFS_W) & ((ADDR_MAX'(1) << idx_w) - ADDR_MAX'(1));
  endfunction

  function automatic logic [1:0] addr_word(input logic [ADDR_MAX-1:0] a);
    return a[3:2];
  endfunction

endpackage
`default_nettype wire

// File: rtl/dm_wb_cache_if.sv
`default_nettype none
// ============================================================================
// Module   : dm_wb_cache_if
// Brief    : CPU-side and memory-side bus bundle of the data cache.
// Revision : 1.0 - initial release
// ============================================================================
interface dm_wb_cache_if #(
  parameter int BIT_W  = 32,
  parameter int ADDR_W = 32
);
  logic                i_proc_cen;
  logic                i_proc_wen;
  logic [ADDR_W-1:0]   i_proc_addr;
  logic [BIT_W-1:0]    i_proc_wdata;
  logic [BIT_W-1:0]    o_proc_rdata;
  logic                o_proc_stall;
  logic                i_proc_finish;
  logic                o_cache_finish;
  logic                o_mem_cen;
  logic                o_mem_wen;
  logic [ADDR_W-1:0]   o_mem_addr;
  logic [4*BIT_W-1:0]  o_mem_wdata;
  logic [4*BIT_W-1:0]  i_mem_rdata;
  logic                i_mem_stall;

  modport slave (
    input  i_proc_cen, i_proc_wen, i_proc_addr, i_proc_wdata, i_proc_finish,
    input  i_mem_rdata, i_mem_stall,
    output o_proc_rdata, o_proc_stall, o_cache_finish,
    output o_mem_cen, o_mem_wen, o_mem_addr, o_mem_wdata
  );

  modport master (
    output i_proc_cen, i_proc_wen, i_proc_addr, i_proc_wdata, i_proc_finish,
    output i_mem_rdata, i_mem_stall,
    input  o_proc_rdata, o_proc_stall, o_cache_finish,
    input  o_mem_cen, o_mem_wen, o_mem_addr, o_mem_wdata
  );
endinterface
`default_nettype wire

// File: rtl/dm_cache_array.sv
`default_nettype none
// ============================================================================
// Module   : dm_cache_array
// Brief    : Valid/dirty/tag/data storage with combinational read port.
// Revision : 1.0 - initial release
// ============================================================================
module dm_cache_array #(
  parameter int BIT_W = 32,
  parameter int TAG_W = 24,
  parameter int IDX_W = 4
) (
  input  wire logic                 i_clk,
  input  wire logic                 i_rst,
  input  wire logic [IDX_W-1:0]     i_rd_idx,
  output logic                      o_rd_valid,
  output logic                      o_rd_dirty,
  output logic [TAG_W-1:0]          o_rd_tag,
  output logic [4*BIT_W-1:0]        o_rd_line,
  input  wire logic                 i_wr_en,
  input  wire logic [IDX_W-1:0]     i_wr_idx,
  input  wire logic [1:0]           i_wr_word,
  input  wire logic [BIT_W-1:0]     i_wr_data,
  input  wire logic                 i_fill_en,
  input  wire logic [IDX_W-1:0]     i_fill_idx,
  input  wire logic [TAG_W-1:0]     i_fill_tag,
  input  wire logic [4*BIT_W-1:0]   i_fill_line,
  input  wire logic                 i_clr_en,
  input  wire logic [IDX_W-1:0]     i_clr_idx
);
  localparam int NLINES = 1 << IDX_W;

  logic [NLINES-1:0]  r_valid;
  logic [NLINES-1:0]  r_dirty;
  logic [TAG_W-1:0]   r_tag  [NLINES];
  logic [4*BIT_W-1:0] r_data [NLINES];

  assign o_rd_valid = r_valid[i_rd_idx];
  assign o_rd_dirty = r_dirty[i_rd_idx];
  assign o_rd_tag   = r_tag[i_rd_idx];
  assign o_rd_line  = r_data[i_rd_idx];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else begin
      if (i_fill_en) begin
        r_valid[i_fill_idx] <= 1'b1;
        r_dirty[i_fill_idx] <= 1'b0;
      end
      if (i_wr_en)  r_dirty[i_wr_idx]  <= 1'b1;
      if (i_clr_en) r_dirty[i_clr_idx] <= 1'b0;
    end
  end

  // Payload needs no reset: a cleared valid bit hides it.
  always_ff @(posedge i_clk) begin
    if (i_fill_en) begin
      r_tag[i_fill_idx]  <= i_fill_tag;
      r_data[i_fill_idx] <= i_fill_line;
    end else if (i_wr_en) begin
      r_data[i_wr_idx][i_wr_word*BIT_W +: BIT_W] <= i_wr_data;
    end
  end

endmodule
`default_nettype wire

// File: rtl/dm_wb_cache.sv
`default_nettype none
// ============================================================================
// Module   : dm_wb_cache
// Brief    : Direct-mapped write-back write-allocate data cache with flush.
//            Optional hit/miss counters when CACHE_PERF_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module dm_wb_cache
  import dm_cache_pkg::*;
#(
  parameter int BIT_W  = 32,
  parameter int ADDR_W = 32,
  parameter int IDX_W  = 4
) (
  input  wire logic        i_clk,
  input  wire logic        i_rst,
  dm_wb_cache_if.slave     bus
`ifdef CACHE_PERF_EN
  ,
  output logic [31:0]      o_hit_cnt,
  output logic [31:0]      o_miss_cnt
`endif
);
  localparam int LINE_W = line_w(BIT_W);
  localparam int TAG_W  = tag_w(ADDR_W, IDX_W);

  state_e              r_state;
  logic [IDX_W-1:0]    r_fl_ptr;
  logic                r_mem_cen;
  logic                r_mem_wen;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [LINE_W-1:0]   r_mem_wdata;
  logic                r_cache_finish;

  logic [TAG_W-1:0]    w_req_tag;
  logic [IDX_W-1:0]    w_req_idx;
  logic [1:0]          w_req_word;
  logic [IDX_W-1:0]    w_rd_idx;
  logic                w_rd_valid;
  logic                w_rd_dirty;
  logic [TAG_W-1:0]    w_rd_tag;
  logic [LINE_W-1:0]   w_rd_line;
  logic [BIT_W-1:0]    w_rd_word;
  logic                w_hit;
  logic                w_flushing;
  logic [ADDR_W-1:0]   w_victim_addr;
  logic [ADDR_W-1:0]   w_req_line_addr;

  assign w_req_tag  = TAG_W'(addr_tag(ADDR_MAX'(bus.i_proc_addr), IDX_W));
  assign w_req_idx  = IDX_W'(addr_idx(ADDR_MAX'(bus.i_proc_addr), IDX_W));
  assign w_req_word = addr_word(ADDR_MAX'(bus.i_proc_addr));

  // The victim always shares the request index, so one read port serves both.
  assign w_flushing = (r_state == FL_SCAN) || (r_state == FL_REQ) || (r_state == FL_WAIT);
  assign w_rd_idx   = w_flushing ? r_fl_ptr : w_req_idx;

  dm_cache_array #(
    .BIT_W (BIT_W),
    .TAG_W (TAG_W),
    .IDX_W (IDX_W)
  ) u_array (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_rd_idx    (w_rd_idx),
    .o_rd_valid  (w_rd_valid),
    .o_rd_dirty  (w_rd_dirty),
    .o_rd_tag    (w_rd_tag),
    .o_rd_line   (w_rd_line),
    .i_wr_en     ((r_state == IDLE) && bus.i_proc_cen && bus.i_proc_wen && w_hit),
    .i_wr_idx    (w_req_idx),
    .i_wr_word   (w_req_word),
    .i_wr_data   (bus.i_proc_wdata),
    .i_fill_en   ((r_state == AL_WAIT) && !bus.i_mem_stall),
    .i_fill_idx  (w_req_idx),
    .i_fill_tag  (w_req_tag),
    .i_fill_line (bus.i_mem_rdata),
    .i_clr_en    (((r_state == WB_WAIT) || (r_state == FL_WAIT)) && !bus.i_mem_stall),
    .i_clr_idx   (w_rd_idx)
  );

  assign w_rd_word       = w_rd_line[w_req_word*BIT_W +: BIT_W];
  assign w_hit           = w_rd_valid && (w_rd_tag == w_req_tag);
  assign w_victim_addr   = {w_rd_tag, w_rd_idx, {OFS_W{1'b0}}};
  assign w_req_line_addr = {w_req_tag, w_req_idx, {OFS_W{1'b0}}};

  assign bus.o_proc_rdata   = ((r_state == IDLE) && bus.i_proc_cen && !bus.i_proc_wen && w_hit)
                              ? w_rd_word : '0;
  assign bus.o_proc_stall   = bus.i_proc_cen && !((r_state == IDLE) && w_hit);
  assign bus.o_mem_cen      = r_mem_cen;
  assign bus.o_mem_wen      = r_mem_wen;
  assign bus.o_mem_addr     = r_mem_addr;
  assign bus.o_mem_wdata    = r_mem_wdata;
  assign bus.o_cache_finish = r_cache_finish;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state        <= IDLE;
      r_fl_ptr       <= '0;
      r_mem_cen      <= 1'b0;
      r_mem_wen      <= 1'b0;
      r_mem_addr     <= '0;
      r_mem_wdata    <= '0;
      r_cache_finish <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          // A pending CPU request takes priority over a flush request.
          if (bus.i_proc_cen) begin
            if (!w_hit) begin
              r_mem_cen <= 1'b1;
              if (w_rd_valid && w_rd_dirty) begin
                r_state     <= WB_REQ;
                r_mem_wen   <= 1'b1;
                r_mem_addr  <= w_victim_addr;
                r_mem_wdata <= w_rd_line;
              end else begin
                r_state    <= AL_REQ;
                r_mem_wen  <= 1'b0;
                r_mem_addr <= w_req_line_addr;
              end
            end
          end else if (bus.i_proc_finish) begin
            r_state  <= FL_SCAN;
            r_fl_ptr <= '0;
          end
        end
        WB_REQ: begin
          r_mem_cen <= 1'b0;
          r_mem_wen <= 1'b0;
          r_state   <= WB_WAIT;
        end
        WB_WAIT: begin
          if (!bus.i_mem_stall) begin
            r_state    <= AL_REQ;
            r_mem_cen  <= 1'b1;
            r_mem_addr <= w_req_line_addr;
          end
        end
        AL_REQ: begin
          r_mem_cen <= 1'b0;
          r_state   <= AL_WAIT;
        end
        AL_WAIT: begin
          if (!bus.i_mem_stall) r_state <= IDLE;
        end
        FL_SCAN: begin
          // After a write-back the same line is rescanned, now clean.
          if (w_rd_valid && w_rd_dirty) begin
            r_state     <= FL_REQ;
            r_mem_cen   <= 1'b1;
            r_mem_wen   <= 1'b1;
            r_mem_addr  <= w_victim_addr;
            r_mem_wdata <= w_rd_line;
          end else if (&r_fl_ptr) begin
            r_state        <= DONE;
            r_cache_finish <= 1'b1;
          end else begin
            r_fl_ptr <= r_fl_ptr + 1'b1;
          end
        end
        FL_REQ: begin
          r_mem_cen <= 1'b0;
          r_mem_wen <= 1'b0;
          r_state   <= FL_WAIT;
        end
        FL_WAIT: begin
          if (!bus.i_mem_stall) r_state <= FL_SCAN;
        end
        DONE: begin
          r_cache_finish <= 1'b1;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

`ifdef CACHE_PERF_EN
  logic r_miss_pend;
  logic w_req_done;

  assign w_req_done = (r_state == IDLE) && bus.i_proc_cen && w_hit;

  // The re-hit that ends a miss is credited to the miss counter only.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_miss_pend <= 1'b0;
      o_hit_cnt   <= '0;
      o_miss_cnt  <= '0;
    end else begin
      if ((r_state == IDLE) && bus.i_proc_cen && !w_hit) r_miss_pend <= 1'b1;
      if (w_req_done) begin
        r_miss_pend <= 1'b0;
        if (r_miss_pend) begin
          if (o_miss_cnt != 32'hFFFF_FFFF) o_miss_cnt <= o_miss_cnt + 32'd1;
        end else begin
          if (o_hit_cnt != 32'hFFFF_FFFF) o_hit_cnt <= o_hit_cnt + 32'd1;
        end
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_dm_wb_cache.sv
`default_nettype none
// ============================================================================
// Module   : tb_dm_wb_cache
// Brief    : Self-checking bench for dm_wb_cache with a latency memory model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_dm_wb_cache;
  localparam int LAT = 2;
  localparam logic [31:0] W_A = 32'h1111_AAAA;
  localparam logic [31:0] W_B = 32'h2222_BBBB;
  localparam logic [31:0] W_C = 32'h3333_CCCC;
  localparam logic [31:0] W_D = 32'h4444_DDDD;

  typedef struct {
    logic [31:0]  a;
    logic [127:0] d;
  } wr_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dm_wb_cache_if #(.BIT_W(32), .ADDR_W(32)) bus();

`ifdef CACHE_PERF_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif

  dm_wb_cache #(.BIT_W(32), .ADDR_W(32), .IDX_W(4)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
`ifdef CACHE_PERF_EN
    ,
    .o_hit_cnt  (hit_cnt),
    .o_miss_cnt (miss_cnt)
`endif
  );

  int vec  = 0;
  int miss = 0;
  logic [31:0] exp_rd_q[$];
  wr_t         exp_wr_q[$];

  // Memory model: stall high in the request cycle and LAT cycles after it.
  bit   [127:0] mem [256];
  bit   [255:0] mwr;
  int           cnt;
  logic [127:0] m_rdata;
  int           rd_n, obs_n, viol;
  bit   [31:0]  last_rd_addr;
  bit   [31:0]  obs_addr [16];
  bit   [127:0] obs_data [16];

  function automatic logic [127:0] init_line(input logic [31:0] a);
    if (a == 32'h0001_0000) return {W_D, W_C, W_B, W_A};
    return {a ^ 32'h5A00_000C, a ^ 32'h5A00_0008, a ^ 32'h5A00_0004, a ^ 32'h5A00_0000};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= 0;
      m_rdata <= '0;
    end else begin
      if (cnt != 0) cnt <= cnt - 1;
      if (bus.o_mem_cen === 1'b1) begin
        if (cnt != 0) viol <= viol + 1;
        cnt <= LAT;
        if (bus.o_mem_wen) begin
          mem[bus.o_mem_addr[11:4]] <= bus.o_mem_wdata;
          mwr[bus.o_mem_addr[11:4]] <= 1'b1;
          if (obs_n < 16) begin
            obs_addr[obs_n[3:0]] <= bus.o_mem_addr;
            obs_data[obs_n[3:0]] <= bus.o_mem_wdata;
          end
          obs_n <= obs_n + 1;
        end else begin
          m_rdata      <= mwr[bus.o_mem_addr[11:4]] ? mem[bus.o_mem_addr[11:4]]
                                                    : init_line(bus.o_mem_addr);
          rd_n         <= rd_n + 1;
          last_rd_addr <= bus.o_mem_addr;
        end
      end
    end
  end

  assign bus.i_mem_stall = bus.o_mem_cen | (cnt != 0);
  assign bus.i_mem_rdata = m_rdata;

  task automatic cpu_access(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                            output logic [31:0] rdata, output int stalls);
    @(posedge clk); #1;
    bus.i_proc_cen   = 1'b1;
    bus.i_proc_wen   = wen;
    bus.i_proc_addr  = addr;
    bus.i_proc_wdata = wdata;
    stalls = 0;
    rdata  = '0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (bus.o_proc_stall === 1'b0) begin
        rdata = bus.o_proc_rdata;
        break;
      end
      stalls++;
    end
    if (stalls >= 200) begin
      vec++; miss++;
      $display("FAIL access_timeout: addr %h stalled %0d cycles, required release", addr, stalls);
    end
    @(posedge clk); #1;
    bus.i_proc_cen = 1'b0;
    bus.i_proc_wen = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    vec++; if (bus.o_mem_cen !== 1'b0) begin miss++; $display("FAIL rst_mem_cen: got %b want 0", bus.o_mem_cen); end
    vec++; if (bus.o_mem_wen !== 1'b0) begin miss++; $display("FAIL rst_mem_wen: got %b want 0", bus.o_mem_wen); end
    vec++; if (bus.o_mem_addr !== 32'h0) begin miss++; $display("FAIL rst_mem_addr: got %h want 0", bus.o_mem_addr); end
    vec++; if (bus.o_mem_wdata !== 128'h0) begin miss++; $display("FAIL rst_mem_wdata: got %h want 0", bus.o_mem_wdata); end
    vec++; if (bus.o_cache_finish !== 1'b0) begin miss++; $display("FAIL rst_finish: got %b want 0", bus.o_cache_finish); end
    vec++; if (bus.o_proc_rdata !== 32'h0) begin miss++; $display("FAIL rst_rdata: got %h want 0", bus.o_proc_rdata); end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    vec++; if (bus.o_proc_stall !== 1'b0) begin miss++; $display("FAIL rst_stall: got %b want 0", bus.o_proc_stall); end
  endtask

  task automatic test_miss_fill();
    logic [31:0] rd, e;
    int st, r0;
    r0 = rd_n;
    exp_rd_q.push_back(W_B);
    cpu_access(1'b0, 32'h0001_0004, 32'h0, rd, st);
    e = exp_rd_q.pop_front();
    vec++; if (rd !== e) begin miss++; $display("FAIL miss_rdata: got %h want %h", rd, e); end
    vec++; if (st !== LAT + 3) begin miss++; $display("FAIL miss_stall_cycles: got %0d want %0d", st, LAT + 3); end
    vec++; if (rd_n - r0 !== 1) begin miss++; $display("FAIL miss_reads: got %0d want 1", rd_n - r0); end
    vec++; if (last_rd_addr !== 32'h0001_0000) begin miss++; $display("FAIL miss_rd_addr: got %h want 00010000", last_rd_addr); end
    exp_rd_q.push_back(W_C);
    cpu_access(1'b0, 32'h0001_0008, 32'h0, rd, st);
    e = exp_rd_q.pop_front();
    vec++; if (rd !== e) begin miss++; $display("FAIL hit_rdata: got %h want %h", rd, e); end
    vec++; if (st !== 0) begin miss++; $display("FAIL hit_stall_cycles: got %0d want 0", st); end
  endtask

  task automatic test_store_hit();
    logic [31:0] rd, e;
    int st, r0, w0;
    r0 = rd_n; w0 = obs_n;
    cpu_access(1'b1, 32'h0001_0000, 32'h1234_5678, rd, st);
    vec++; if (st !== 0) begin miss++; $display("FAIL store_stall: got %0d want 0", st); end
    vec++; if ((rd_n - r0) + (obs_n - w0) !== 0) begin
      miss++; $display("FAIL store_mem_traffic: got %0d requests want 0", (rd_n - r0) + (obs_n - w0));
    end
    exp_rd_q.push_back(32'h1234_5678);
    cpu_access(1'b0, 32'h0001_0000, 32'h0, rd, st);
    e = exp_rd_q.pop_front();
    vec++; if (rd !== e) begin miss++; $display("FAIL store_reload: got %h want %h", rd, e); end
  endtask

  task automatic test_dirty_evict();
    logic [31:0]  rd, e;
    logic [127:0] l;
    wr_t          w;
    int st, r0, w0;
    r0 = rd_n; w0 = obs_n;
    exp_wr_q.push_back('{32'h0001_0000, {W_D, W_C, W_B, 32'h1234_5678}});
    l = init_line(32'h0001_0100);
    exp_rd_q.push_back(l[31:0]);
    cpu_access(1'b0, 32'h0001_0100, 32'h0, rd, st);
    e = exp_rd_q.pop_front();
    vec++; if (rd !== e) begin miss++; $display("FAIL evict_rdata: got %h want %h", rd, e); end
    vec++; if (st !== 2 * LAT + 5) begin miss++; $display("FAIL evict_stall_cycles: got %0d want %0d", st, 2 * LAT + 5); end
    vec++; if (obs_n - w0 !== 1) begin miss++; $display("FAIL evict_writes: got %0d want 1", obs_n - w0); end
    w = exp_wr_q.pop_front();
    vec++; if (obs_addr[w0] !== w.a) begin miss++; $display("FAIL evict_wr_addr: got %h want %h", obs_addr[w0], w.a); end
    vec++; if (obs_data[w0] !== w.d) begin miss++; $display("FAIL evict_wr_data: got %h want %h", obs_data[w0], w.d); end
    vec++; if (last_rd_addr !== 32'h0001_0100 || rd_n - r0 !== 1) begin
      miss++; $display("FAIL evict_refill: got addr %h count %0d want 00010100 count 1", last_rd_addr, rd_n - r0);
    end
  endtask

  task automatic test_flush();
    logic [31:0]  rd;
    logic [127:0] l;
    wr_t          w;
    int st, r0, w0;
    bit done;
    cpu_access(1'b1, 32'h0001_0104, 32'hCAFE_0001, rd, st);
    vec++; if (st !== 0) begin miss++; $display("FAIL flush_prep_hit: got %0d want 0", st); end
    cpu_access(1'b1, 32'h0001_00F0, 32'hBEEF_000F, rd, st);
    vec++; if (st !== LAT + 3) begin miss++; $display("FAIL flush_prep_miss: got %0d want %0d", st, LAT + 3); end
    l = init_line(32'h0001_0100); l[63:32] = 32'hCAFE_0001;
    exp_wr_q.push_back('{32'h0001_0100, l});
    l = init_line(32'h0001_00F0); l[31:0] = 32'hBEEF_000F;
    exp_wr_q.push_back('{32'h0001_00F0, l});
    r0 = rd_n; w0 = obs_n; done = 1'b0;
    @(posedge clk); #1 bus.i_proc_finish = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (bus.o_cache_finish === 1'b1) begin done = 1'b1; break; end
    end
    bus.i_proc_finish = 1'b0;
    vec++; if (!done) begin miss++; $display("FAIL flush_timeout: finish %b want 1", bus.o_cache_finish); end
    vec++; if (obs_n - w0 !== 2) begin miss++; $display("FAIL flush_writes: got %0d want 2", obs_n - w0); end
    for (int k = 0; k < 2; k++) begin
      w = exp_wr_q.pop_front();
      vec++; if (obs_addr[w0 + k] !== w.a || obs_data[w0 + k] !== w.d) begin
        miss++; $display("FAIL flush_wr%0d: got %h/%h want %h/%h", k, obs_addr[w0 + k], obs_data[w0 + k], w.a, w.d);
      end
    end
    @(posedge clk); #1;
    bus.i_proc_cen = 1'b1; bus.i_proc_wen = 1'b0; bus.i_proc_addr = 32'h0001_0100;
    repeat (3) @(negedge clk);
    vec++; if (bus.o_proc_stall !== 1'b1 || bus.o_cache_finish !== 1'b1) begin
      miss++; $display("FAIL done_hold: got stall %b finish %b want 1 1", bus.o_proc_stall, bus.o_cache_finish);
    end
    @(posedge clk); #1 bus.i_proc_cen = 1'b0;
    vec++; if (rd_n - r0 !== 0 || obs_n - w0 !== 2) begin
      miss++; $display("FAIL done_traffic: got reads %0d writes %0d want 0 2", rd_n - r0, obs_n - w0);
    end
  endtask

  task automatic test_reset_abort();
    logic [31:0]  rd, e;
    logic [127:0] l;
    int st, r0, r1;
    bit seen;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    vec++; if (bus.o_cache_finish !== 1'b0) begin miss++; $display("FAIL abort_finish_clr: got %b want 0", bus.o_cache_finish); end
    r0 = rd_n; seen = 1'b0;
    @(posedge clk); #1;
    bus.i_proc_cen = 1'b1; bus.i_proc_wen = 1'b0; bus.i_proc_addr = 32'h0001_0200;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.o_mem_cen === 1'b1) begin seen = 1'b1; break; end
    end
    vec++; if (!seen) begin miss++; $display("FAIL abort_no_request: mem_cen %b want 1", bus.o_mem_cen); end
    @(posedge clk); #1;
    rst = 1'b1; bus.i_proc_cen = 1'b0;
    #1;
    vec++; if (bus.o_mem_cen !== 1'b0 || bus.o_proc_stall !== 1'b0) begin
      miss++; $display("FAIL abort_outputs: got cen %b stall %b want 0 0", bus.o_mem_cen, bus.o_proc_stall);
    end
    r1 = rd_n;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) @(negedge clk);
    vec++; if (rd_n !== r1 || r1 - r0 !== 1) begin
      miss++; $display("FAIL abort_reissue: got reads %0d after reset want 0", rd_n - r1);
    end
    exp_rd_q.push_back(W_B);
    cpu_access(1'b0, 32'h0001_0004, 32'h0, rd, st);
    e = exp_rd_q.pop_front();
    vec++; if (rd !== e || st !== LAT + 3) begin
      miss++; $display("FAIL abort_refetch: got %h/%0d want %h/%0d", rd, st, e, LAT + 3);
    end
    exp_rd_q.push_back(32'hBEEF_000F);
    cpu_access(1'b0, 32'h0001_00F0, 32'h0, rd, st);
    e = exp_rd_q.pop_front();
    vec++; if (rd !== e || st !== LAT + 3) begin
      miss++; $display("FAIL flushed_data: got %h/%0d want %h/%0d", rd, st, e, LAT + 3);
    end
`ifdef CACHE_PERF_EN
    exp_rd_q.push_back(32'h1234_5678);
    exp_rd_q.push_back(W_C);
    l = init_line(32'h0001_00F0);
    exp_rd_q.push_back(l[63:32]);
    cpu_access(1'b0, 32'h0001_0000, 32'h0, rd, st);
    e = exp_rd_q.pop_front();
    vec++; if (rd !== e) begin miss++; $display("FAIL perf_hit0: got %h want %h", rd, e); end
    cpu_access(1'b0, 32'h0001_0008, 32'h0, rd, st);
    e = exp_rd_q.pop_front();
    vec++; if (rd !== e) begin miss++; $display("FAIL perf_hit1: got %h want %h", rd, e); end
    cpu_access(1'b0, 32'h0001_00F4, 32'h0, rd, st);
    e = exp_rd_q.pop_front();
    vec++; if (rd !== e) begin miss++; $display("FAIL perf_hit2: got %h want %h", rd, e); end
    vec++; if (hit_cnt !== 32'd3 || miss_cnt !== 32'd2) begin
      miss++; $display("FAIL perf_counts: got hit %0d miss %0d want 3 2", hit_cnt, miss_cnt);
    end
`else
    l = '0;
`endif
  endtask

  initial begin
    bus.i_proc_cen    = 1'b0;
    bus.i_proc_wen    = 1'b0;
    bus.i_proc_addr   = '0;
    bus.i_proc_wdata  = '0;
    bus.i_proc_finish = 1'b0;
    test_reset();
    test_miss_fill();
    test_store_hit();
    test_dirty_evict();
    test_flush();
    test_reset_abort();
    vec++; if (viol !== 0) begin miss++; $display("FAIL mem_overlap: got %0d overlapping requests want 0", viol); end
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dm_wb_cache.md
# dm_wb_cache

Direct-mapped, write-back, write-allocate data cache between the CPU's word-wide data port and the line-wide (4×32-bit) slow data memory. Hits complete in the request cycle. Misses evict a dirty victim line and refill over the memory's cen/wen/stall protocol. A finish request flushes all dirty lines so the bench can compare final memory contents.

## Interface
Parameters:
- BIT_W, 32, data word width
- ADDR_W, 32, byte-address width
- IDX_W, 4, index bits (2^IDX_W lines of 4 words each)

Ports:
- i_clk  in  1  clock, rising edge
- i_rst  in  1  reset, asynchronous, active-high
- i_proc_cen  in  1  CPU request valid
- i_proc_wen  in  1  1 = store, 0 = load
- i_proc_addr  in  ADDR_W  byte address; bits [1:0] ignored
- i_proc_wdata  in  BIT_W  store data
- o_proc_rdata  out  BIT_W  load data, valid when cen && !wen && !stall
- o_proc_stall  out  1  CPU must hold all request inputs stable while high
- i_proc_finish  in  1  start flush; sampled only in IDLE
- o_cache_finish  out  1  flush complete; sticky until reset
- o_mem_cen  out  1  memory request, exactly one cycle per transaction
- o_mem_wen  out  1  memory write
- o_mem_addr  out  ADDR_W  line-aligned byte address {tag, index, 4'b0}
- o_mem_wdata  out  4*BIT_W  victim line, word 0 in LSBs
- i_mem_rdata  in  4*BIT_W  refill line
- i_mem_stall  in  1  memory busy

## Operation
- Address split: word offset [3:2], index [IDX_W+3:4], tag [ADDR_W-1:IDX_W+4].
- Per-line storage: valid, dirty, tag, 4×BIT_W data.
- FSM states: IDLE, WB_REQ, WB_WAIT, AL_REQ, AL_WAIT, FL_SCAN, FL_REQ, FL_WAIT, DONE.
- IDLE, cen with hit (valid && tag match):
  - Load: o_proc_rdata = selected word combinationally; stall=0.
  - Store: write the word and set dirty on the next edge; stall=0.
- IDLE, cen with miss: stall=1 in the same cycle.
  - Victim valid && dirty: go to WB_REQ.
  - Otherwise: go to AL_REQ.
- WB_REQ: mem_cen=1, mem_wen=1, addr = victim {tag,idx}, wdata = victim line. Go to WB_WAIT.
- WB_WAIT: wait for i_mem_stall=0, then clear dirty and go to AL_REQ.
- AL_REQ: mem_cen=1, mem_wen=0, addr = request line. Go to AL_WAIT.
- AL_WAIT: in the first cycle with i_mem_stall=0:
  - Capture i_mem_rdata; set valid=1, dirty=0, tag = request tag.
  - Go to IDLE, where the held request re-evaluates as a hit.
- Flush:
  - IDLE with i_proc_finish and no pending cen: go to FL_SCAN with pointer = 0.
  - FL_SCAN: if the pointed line is dirty, go to FL_REQ/FL_WAIT (same signalling as WB), clear its dirty bit, then return to FL_SCAN. Otherwise increment the pointer.
  - After line 2^IDX_W−1: go to DONE.
- DONE: o_cache_finish=1, stall=1 for any cen. Left only by reset.
- Simultaneous i_proc_finish and i_proc_cen in IDLE: serve cen first; finish remains pending.

## Timing
- Reset: FSM=IDLE; all valid/dirty bits=0; flush pointer=0; o_mem_cen=0, o_mem_wen=0, o_mem_addr=0, o_mem_wdata=0; o_cache_finish=0; o_proc_rdata=0; o_proc_stall=0 while cen=0.
- Reset asserted mid-transaction aborts it immediately. No memory request is reissued after reset.
- Hit latency: 0 cycles.
- Clean miss latency: 1 (AL_REQ) + memory read latency + 1 (re-hit).
- Dirty miss adds 1 + memory write latency.
- Memory requests: o_mem_cen is a single-cycle pulse. The cache never issues a new request before the stall of the previous one has fallen.
- i_mem_stall is ignored in the same cycle as o_mem_cen, because memory stall is combinational on cen.

## Configuration
- CACHE_PERF_EN:
  - Defined: adds output ports o_hit_cnt and o_miss_cnt (32 bits each, reset 0). Each counts once per completed CPU request; a miss's re-hit is not counted as a hit. Counters saturate at 0xFFFF_FFFF.
  - Undefined: the ports and counters do not exist.

## Structure
- Package dm_cache_pkg holds:
  - State encoding (9 states).
  - LINE_W = 4*BIT_W, OFS_W = 4, TAG_W derivation.
  - Field-extract functions for tag, index and word.
- Sub-module dm_cache_array holds the valid/dirty/tag/data registers:
  - Combinational read port.
  - Separate word-write and line-fill write ports.
  - Dirty-clear strobe.
  - Reset clear.

## Test plan
- Memory preloaded with line 0x0001_0000 = {D,C,B,A}. Load 0x0001_0004 → stall for 1+read latency+1 cycles, rdata=B. Load 0x0001_0008 next → stall=0, rdata=C same cycle.
- Store 0x1234_5678 to 0x0001_0000 (hit after fill) → stall=0, no o_mem_cen. Reload 0x0001_0000 → 0x1234_5678.
- Dirty conflict (same index, IDX_W=4): access 0x0001_0100 after the store above → WB_REQ with mem addr 0x0001_0000 and wdata word0 = 0x1234_5678, then AL_REQ to 0x0001_0100.
- Flush with lines 0 and 15 dirty → exactly two write pulses (index 0 first), then o_cache_finish=1 and held.
- Assert i_rst during AL_WAIT → o_mem_cen=0, all lines invalid; repeat the load → full miss.
- With CACHE_PERF_EN: 3 hits + 2 misses → o_hit_cnt=3, o_miss_cnt=2.
